wfg_cfg_loader: RTL and testbench
=================================

# wfg_cfg_loader

Boot-time configuration sequencer that sits directly upstream of the waveform generator top level as a Wishbone master. On a start pulse it walks a table of (register address, data) word pairs held in a 1K x 32 single-port ROM/RAM. For each pair it issues one Wishbone write into the generator's register pages (0x10–0x60). It stops at a null-page terminator, on table overflow, or on an ack timeout, then releases the bus and reports status to the host.

## Interface
Parameters:
- BUSW, 32: Wishbone address/data width.
- AW, 10: table memory address width.
- TIMEOUT, 16: cycles to wait for `wbm_ack_i` before aborting; minimum 2.

Ports:
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_ni  in  1  reset, synchronous, active-low.
- start_i  in  1  one-cycle start request; sampled only in IDLE.
- base_addr_i  in  AW  first table word address; sampled with start_i.
- busy_o  out  1  high from the cycle after start is accepted until DONE completes.
- done_o  out  1  one-cycle pulse in DONE.
- err_o  out  1  sticky error flag; cleared when start is accepted.
- err_code_o  out  2  0 none, 1 ack timeout, 2 table overflow, 3 readback mismatch.
- words_o  out  AW  count of completed writes; cleared on start.
- csb_o  out  1  memory chip select, active-low.
- addr_o  out  AW  memory address.
- dout_i  in  32  memory read data, valid the cycle after csb_o=0.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master controls.
- wbm_adr_o, wbm_dat_o  out  BUSW each  Wishbone address and write data.
- wbm_dat_i  in  BUSW  Wishbone read data.
- wbm_ack_i  in  1  Wishbone acknowledge.

## Operation
- Table format: even word = target address, odd word = data. An address word with bits [BUSW-1:4]==0 (null page) terminates the table without error.
- FSM states:
  - IDLE: on start_i, ptr<=base_addr_i, clear err/words, go to FETCH_A.
  - FETCH_A: csb_o=0, addr_o=ptr.
  - WAIT_A: latch dout_i into adr_q.
    - If null page: go to DONE.
    - Else if ptr==2^AW-1: err_code=2, go to DONE.
    - Else ptr++, go to FETCH_D.
  - FETCH_D: csb_o=0, addr_o=ptr.
  - WAIT_D: latch dat_q; ptr++ (wraps to 0, flagged in ovf_q); go to WB_WR.
  - WB_WR: cyc=stb=we=1, adr=adr_q, dat=dat_q, held stable until ack.
    - On ack: words++. If ovf_q: err_code=2, go to DONE. Otherwise go to FETCH_A, or WB_RD if readback is compiled in.
  - DONE: done_o=1 for one cycle, then IDLE.
- Timeout: a counter runs while cyc is high and ack is not seen. When it reaches TIMEOUT-1 with no ack, cyc/stb drop, err_code=1, and the FSM goes to DONE. Ack arriving in that same cycle wins over the timeout.
- start_i is ignored while busy_o=1.
- csb_o=1 in every state other than FETCH_x. wbm_* controls are 0 outside the bus states. wbm_adr_o and wbm_dat_o may hold stale values.

## Timing
- Reset (wb_rst_ni low at a clock edge): state IDLE; busy_o=0, done_o=0, err_o=0, err_code_o=0, words_o=0, csb_o=1, addr_o=0, wbm_cyc/stb/we=0, wbm_adr/dat=0.
- Reset mid-transfer drops cyc/stb in the cycle after the reset edge. No ack is awaited.
- Start sampled in cycle 0. busy_o and FETCH_A in cycle 1. WAIT_A cycle 2, FETCH_D cycle 3, WAIT_D cycle 4. First wbm_stb_o in cycle 5.
- With ack L cycles after stb rises (L≥0), the next FETCH_A occurs at cycle 5+L+1. One pair costs 5+L cycles.
- A zero-entry table (terminator at base) gives done_o in cycle 3 and busy_o low in cycle 4.
- Back-to-back: start_i in the same cycle as done_o is ignored. start_i is accepted from the following cycle (IDLE) onward.

## Configuration
- WFG_CFG_LOADER_READBACK_EN defined:
  - After each acked write, the FSM enters WB_RD: cyc=stb=1, we=0, same address, same timeout rule.
  - On ack it compares wbm_dat_i with dat_q. A mismatch sets err_code=3 and goes to DONE; a match goes to FETCH_A.
  - Per-pair cost grows by the read latency L'+1.
- Undefined: WB_RD does not exist, wbm_dat_i is unused, and err_code 3 never occurs.

## Test plan
- Table at base 0x000: {0x10,0x1; 0x50,0xABCD; 0x0}, slave acks 1 cycle after stb. Expect:
  - writes 0x10←0x1, then 0x50←0xABCD;
  - stb first rising in cycle 5;
  - done_o pulse, words_o=2, err_o=0.
- Terminator at base 0x3FF, i.e. a single word 0x00000000. Expect done_o in cycle 3, no bus cycle, words_o=0.
- Address word at 0x3FF is 0x20. Expect err_code_o=2, words_o=0, no write. Second case: pair at 0x3FE/0x3FF. Expect one write, then err_code_o=2.
- Slave never acks with TIMEOUT=16. Expect stb high exactly 16 cycles, then drop, err_code_o=1, done_o. A new start clears err_o.
- wb_rst_ni asserted during WB_WR. Expect cyc/stb low the next cycle, all outputs at reset values, and start_i still honoured afterwards.
- With WFG_CFG_LOADER_READBACK_EN, slave returns 0xABCC for the address written with 0xABCD. Expect the write, then the read, then err_code_o=3 and words_o=1.

Source files
------------

// File: rtl/wfg_cfg_loader.sv
// Boot-time Wishbone configuration sequencer: walks (address, data) pairs from a table memory into the generator.
// Optional readback-verify of each write is compiled in with WFG_CFG_LOADER_READBACK_EN.
module wfg_cfg_loader #(
  parameter int BUSW    = 32,
  parameter int AW      = 10,
  parameter int TIMEOUT = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            start_i,
  input  logic [AW-1:0]   base_addr_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [1:0]      err_code_o,
  output logic [AW-1:0]   words_o,
  output logic            csb_o,
  output logic [AW-1:0]   addr_o,
  input  logic [31:0]     dout_i,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [BUSW-1:0] wbm_adr_o,
  output logic [BUSW-1:0] wbm_dat_o,
  input  logic [BUSW-1:0] wbm_dat_i,
  input  logic            wbm_ack_i
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [AW-1:0] PTR_MAX = {AW{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH_A = 3'd1,
    ST_WAIT_A  = 3'd2,
    ST_FETCH_D = 3'd3,
    ST_WAIT_D  = 3'd4,
    ST_WB_WR   = 3'd5,
    ST_WB_RD   = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  state_t          state_r;
  logic [AW-1:0]   ptr_r;
  logic [AW-1:0]   addr_r;
  logic [AW-1:0]   words_r;
  logic [BUSW-1:0] adr_q_r;
  logic [BUSW-1:0] wbm_adr_r;
  logic [BUSW-1:0] wbm_dat_r;
  logic [CW-1:0]   tmo_cnt_r;
  logic [1:0]      err_code_r;
  logic            ovf_r;
  logic            busy_r;
  logic            done_r;
  logic            err_r;
  logic            csb_r;
  logic            cyc_r;
  logic            stb_r;
  logic            we_r;

  logic [BUSW-1:0] rd_word_s;
  logic            null_page_s;
  logic            timeout_s;

  assign rd_word_s   = BUSW'(dout_i);
  assign null_page_s = (rd_word_s[BUSW-1:4] == '0);
  assign timeout_s   = (tmo_cnt_r == CW'(TIMEOUT - 1));

`ifdef WFG_CFG_LOADER_READBACK_EN
  logic [BUSW-1:0] dat_q_r;
`else
  logic unused_rd_s;
  assign unused_rd_s = ^wbm_dat_i;
`endif

  // Sequencer FSM; every output is registered and updated on the transition into the state that drives it.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_r    <= ST_IDLE;
      ptr_r      <= '0;
      addr_r     <= '0;
      words_r    <= '0;
      adr_q_r    <= '0;
      wbm_adr_r  <= '0;
      wbm_dat_r  <= '0;
      tmo_cnt_r  <= '0;
      err_code_r <= 2'd0;
      ovf_r      <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      csb_r      <= 1'b1;
      cyc_r      <= 1'b0;
      stb_r      <= 1'b0;
      we_r       <= 1'b0;
`ifdef WFG_CFG_LOADER_READBACK_EN
      dat_q_r    <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start_i) begin
            ptr_r      <= base_addr_i;
            addr_r     <= base_addr_i;
            csb_r      <= 1'b0;
            busy_r     <= 1'b1;
            err_r      <= 1'b0;
            err_code_r <= 2'd0;
            words_r    <= '0;
            ovf_r      <= 1'b0;
            state_r    <= ST_FETCH_A;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FETCH_A: begin
          csb_r   <= 1'b1;
          state_r <= ST_WAIT_A;
        end
        ST_WAIT_A: begin
          adr_q_r <= rd_word_s;
          if (null_page_s) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else if (ptr_r == PTR_MAX) begin
            err_r      <= 1'b1;
            err_code_r <= 2'd2;
            done_r     <= 1'b1;
            state_r    <= ST_DONE;
          end else begin
            ptr_r   <= ptr_r + AW'(1);
            addr_r  <= ptr_r + AW'(1);
            csb_r   <= 1'b0;
            state_r <= ST_FETCH_D;
          end
        end
        ST_FETCH_D: begin
          csb_r   <= 1'b1;
          state_r <= ST_WAIT_D;
        end
        ST_WAIT_D: begin
          // A data word at the last table slot wraps the pointer; the write still goes out.
          ovf_r     <= (ptr_r == PTR_MAX);
          ptr_r     <= ptr_r + AW'(1);
          wbm_adr_r <= adr_q_r;
          wbm_dat_r <= rd_word_s;
          cyc_r     <= 1'b1;
          stb_r     <= 1'b1;
          we_r      <= 1'b1;
          tmo_cnt_r <= '0;
          state_r   <= ST_WB_WR;
`ifdef WFG_CFG_LOADER_READBACK_EN
          dat_q_r   <= rd_word_s;
`endif
        end
        ST_WB_WR: begin
          if (wbm_ack_i) begin
            words_r   <= words_r + AW'(1);
            tmo_cnt_r <= '0;
            if (ovf_r) begin
              cyc_r      <= 1'b0;
              stb_r      <= 1'b0;
              we_r       <= 1'b0;
              err_r      <= 1'b1;
              err_code_r <= 2'd2;
              done_r     <= 1'b1;
              state_r    <= ST_DONE;
            end else begin
`ifdef WFG_CFG_LOADER_READBACK_EN
              we_r    <= 1'b0;
              state_r <= ST_WB_RD;
`else
              cyc_r   <= 1'b0;
              stb_r   <= 1'b0;
              we_r    <= 1'b0;
              addr_r  <= ptr_r;
              csb_r   <= 1'b0;
              state_r <= ST_FETCH_A;
`endif
            end
          end else if (timeout_s) begin
            cyc_r      <= 1'b0;
            stb_r      <= 1'b0;
            we_r       <= 1'b0;
            err_r      <= 1'b1;
            err_code_r <= 2'd1;
            done_r     <= 1'b1;
            state_r    <= ST_DONE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CW'(1);
          end
        end
`ifdef WFG_CFG_LOADER_READBACK_EN
        ST_WB_RD: begin
          if (wbm_ack_i) begin
            cyc_r     <= 1'b0;
            stb_r     <= 1'b0;
            tmo_cnt_r <= '0;
            if (wbm_dat_i != dat_q_r) begin
              err_r      <= 1'b1;
              err_code_r <= 2'd3;
              done_r     <= 1'b1;
              state_r    <= ST_DONE;
            end else begin
              addr_r  <= ptr_r;
              csb_r   <= 1'b0;
              state_r <= ST_FETCH_A;
            end
          end else if (timeout_s) begin
            cyc_r      <= 1'b0;
            stb_r      <= 1'b0;
            err_r      <= 1'b1;
            err_code_r <= 2'd1;
            done_r     <= 1'b1;
            state_r    <= ST_DONE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CW'(1);
          end
        end
`endif
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          cyc_r   <= 1'b0;
          stb_r   <= 1'b0;
          we_r    <= 1'b0;
          csb_r   <= 1'b1;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign err_o      = err_r;
  assign err_code_o = err_code_r;
  assign words_o    = words_r;
  assign csb_o      = csb_r;
  assign addr_o     = addr_r;
  assign wbm_cyc_o  = cyc_r;
  assign wbm_stb_o  = stb_r;
  assign wbm_we_o   = we_r;
  assign wbm_adr_o  = wbm_adr_r;
  assign wbm_dat_o  = wbm_dat_r;

endmodule

// File: tb/tb_wfg_cfg_loader.sv
// Table-driven bench for wfg_cfg_loader: table memory model, Wishbone slave with programmable ack latency.
module tb_wfg_cfg_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = 10'd0;
  logic        busy, done, err, csb, cyc, stb, we, ack;
  logic [1:0]  err_code;
  logic [9:0]  words, addr;
  logic [31:0] dout = 32'd0;
  logic [31:0] wadr, wdat, rdat;

  logic [31:0] mem [1024];
  int          lat = 0;
  bit          noack = 1'b0;
  logic [7:0]  stb_cnt = 8'd0;
  int          wr_total = 0;
  logic [31:0] wr_adr_log [64];
  logic [31:0] wr_dat_log [64];
  logic [31:0] last_wr_dat = 32'd0;

  int checks = 0;
  int errors = 0;

  wfg_cfg_loader dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start), .base_addr_i(base_addr),
    .busy_o(busy), .done_o(done), .err_o(err), .err_code_o(err_code), .words_o(words),
    .csb_o(csb), .addr_o(addr), .dout_i(dout),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(wadr), .wbm_dat_o(wdat),
    .wbm_dat_i(rdat), .wbm_ack_i(ack)
  );

  always #5 clk = ~clk;

  // Table memory: data valid the cycle after chip select.
  always @(posedge clk) if (!csb) dout <= mem[addr];

  // Wishbone slave: ack lat cycles after stb rises; 0x50 reads back corrupted.
  assign ack  = stb && !noack && (int'(stb_cnt) == lat);
  assign rdat = (wadr == 32'h50) ? 32'hABCC : last_wr_dat;
  always @(posedge clk) begin
    if (!stb || ack) stb_cnt <= 8'd0;
    else             stb_cnt <= stb_cnt + 8'd1;
    if (rst_n && cyc && stb && we && ack) begin
      wr_adr_log[wr_total[5:0]] <= wadr;
      wr_dat_log[wr_total[5:0]] <= wdat;
      last_wr_dat <= wdat;
      wr_total <= wr_total + 1;
    end
  end

  typedef struct {
    logic [9:0]       base;
    int               nw;
    logic [4:0][31:0] w;
    int               lat;
    bit               noack;
    int               e_stb, e_done, e_idle, e_stbn, e_words, e_code, e_wrs;
    logic [31:0]      e_wadr, e_wdat;
  } vec_t;

`ifdef WFG_CFG_LOADER_READBACK_EN
  localparam int NV = 8;
`else
  localparam int NV = 7;
`endif
  vec_t v [NV];

  function automatic vec_t mk(logic [9:0] b, int n, logic [31:0] w0, logic [31:0] w1,
                              logic [31:0] w2, int l, bit na, int es, int ed, int ei, int en,
                              int ew, int ec, int er, logic [31:0] ea, logic [31:0] edat);
    vec_t r;
    r.base = b; r.nw = n; r.w = '0; r.w[0] = w0; r.w[1] = w1; r.w[2] = w2;
    r.lat = l; r.noack = na; r.e_stb = es; r.e_done = ed; r.e_idle = ei; r.e_stbn = en;
    r.e_words = ew; r.e_code = ec; r.e_wrs = er; r.e_wadr = ea; r.e_wdat = edat;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual %0h required %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_reset_values(input int idx);
    chk("rst_cyc", idx, 32'(cyc), 32'd0);
    chk("rst_stb", idx, 32'(stb), 32'd0);
    chk("rst_we", idx, 32'(we), 32'd0);
    chk("rst_busy", idx, 32'(busy), 32'd0);
    chk("rst_done", idx, 32'(done), 32'd0);
    chk("rst_err", idx, 32'(err), 32'd0);
    chk("rst_code", idx, 32'(err_code), 32'd0);
    chk("rst_words", idx, 32'(words), 32'd0);
    chk("rst_csb", idx, 32'(csb), 32'd1);
    chk("rst_addr", idx, 32'(addr), 32'd0);
    chk("rst_wadr", idx, wadr, 32'd0);
    chk("rst_wdat", idx, wdat, 32'd0);
  endtask

  task automatic start_vec(input int i);
    for (int j = 0; j < v[i].nw; j++) begin
      logic [9:0] a;
      a = v[i].base + 10'(j);
      mem[a] = v[i].w[j];
    end
    lat = v[i].lat;
    noack = v[i].noack;
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = v[i].base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int first_stb, first_done, idle, stbn, wr0, wrs;
    first_stb = -1; first_done = -1; idle = -1; stbn = 0;
    wr0 = wr_total;
    start_vec(i);
    for (int k = 1; k <= 100; k++) begin
      if (k == 1) begin
        chk("busy_c1", i, 32'(busy), 32'd1);
        chk("err_clr", i, 32'(err), 32'd0);
        chk("words_clr", i, 32'(words), 32'd0);
      end
      if (stb) begin
        if (first_stb < 0) first_stb = k;
        stbn++;
      end
      if (done && first_done < 0) first_done = k;
      if (!busy) begin
        idle = k;
        break;
      end
      @(posedge clk); #1;
    end
    wrs = wr_total - wr0;
    chk("first_stb", i, 32'(first_stb), 32'(v[i].e_stb));
    chk("done_cyc", i, 32'(first_done), 32'(v[i].e_done));
    chk("idle_cyc", i, 32'(idle), 32'(v[i].e_idle));
    chk("stb_cycles", i, 32'(stbn), 32'(v[i].e_stbn));
    chk("words", i, 32'(words), 32'(v[i].e_words));
    chk("err_code", i, 32'(err_code), 32'(v[i].e_code));
    chk("err_o", i, 32'(err), (v[i].e_code != 0) ? 32'd1 : 32'd0);
    chk("n_writes", i, 32'(wrs), 32'(v[i].e_wrs));
    if (v[i].e_wrs > 0 && wrs > 0) begin
      chk("wr_adr", i, wr_adr_log[wr0[5:0]], v[i].e_wadr);
      chk("wr_dat", i, wr_dat_log[wr0[5:0]], v[i].e_wdat);
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 32'hFFFF_FFF0;
`ifdef WFG_CFG_LOADER_READBACK_EN
    v[0] = mk(10'h000, 5, 32'h10, 32'h1, 32'h50, 1, 0, 5, 17, 18, 8, 2, 3, 2, 32'h10, 32'h1);
    v[5] = mk(10'h010, 3, 32'h60, 32'hDEAD, 32'hF, 3, 0, 5, 15, 16, 8, 1, 0, 1, 32'h60, 32'hDEAD);
    v[6] = mk(10'h020, 3, 32'h40, 32'h9, 32'h0, 15, 0, 5, 39, 40, 32, 1, 0, 1, 32'h40, 32'h9);
    v[7] = mk(10'h100, 3, 32'h50, 32'hABCD, 32'h0, 1, 0, 5, 9, 10, 4, 1, 3, 1, 32'h50, 32'hABCD);
`else
    v[0] = mk(10'h000, 5, 32'h10, 32'h1, 32'h50, 1, 0, 5, 15, 16, 4, 2, 0, 2, 32'h10, 32'h1);
    v[5] = mk(10'h010, 3, 32'h60, 32'hDEAD, 32'hF, 3, 0, 5, 11, 12, 4, 1, 0, 1, 32'h60, 32'hDEAD);
    v[6] = mk(10'h020, 3, 32'h40, 32'h9, 32'h0, 15, 0, 5, 23, 24, 16, 1, 0, 1, 32'h40, 32'h9);
`endif
    v[0].w[3] = 32'hABCD;
    v[0].w[4] = 32'h0;
    v[1] = mk(10'h3FF, 1, 32'h0, 32'h0, 32'h0, 0, 0, -1, 3, 4, 0, 0, 0, 0, 32'h0, 32'h0);
    v[2] = mk(10'h3FF, 1, 32'h20, 32'h0, 32'h0, 0, 0, -1, 3, 4, 0, 0, 2, 0, 32'h0, 32'h0);
    v[3] = mk(10'h3FE, 2, 32'h30, 32'h77, 32'h0, 0, 0, 5, 6, 7, 1, 1, 2, 1, 32'h30, 32'h77);
    v[4] = mk(10'h200, 3, 32'h40, 32'h5, 32'h0, 0, 1, 5, 21, 22, 16, 0, 1, 0, 32'h0, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    check_reset_values(0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Reset in the middle of a write: bus drops on the very next cycle.
    start_vec(4);
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_stb", 1, 32'(stb), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_values(1);
    rst_n = 1'b1;
    run_vec(0);

    // Start held during DONE is ignored; start in the following IDLE cycle is accepted.
    begin
      int k;
      start_vec(1);
      k = 1;
      while (!done && k < 50) begin
        @(posedge clk); #1;
        k++;
      end
      chk("b2b_done_seen", 2, 32'(done), 32'd1);
      start = 1'b1;
      @(posedge clk); #1;
      chk("b2b_ignored", 2, 32'(busy), 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b_accepted", 2, 32'(busy), 32'd1);
      k = 0;
      while (busy && k < 50) begin
        @(posedge clk); #1;
        k++;
      end
      chk("b2b_finish", 2, 32'(busy), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
